muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// CALC cycle on operand magnitudes; FIX applies signs and commits HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;     // original dividend, returned as HI on divide-by-zero
    logic [WIDTH-1:0] acc;     // product upper half / partial remainder
    logic [WIDTH-1:0] q;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs;     // multiplicand / divisor magnitude
    logic             a_neg, b_neg, b_zero;

    // Operand signs only matter for the signed ops (op[0] == 0)
    logic             a_sgn, b_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_sgn = ~op[0] & a[WIDTH-1];
    assign b_sgn = ~op[0] & b[WIDTH-1];
    assign a_mag = a_sgn ? -a : a;
    assign b_mag = b_sgn ? -b : b;

    // One multiply step: conditional add, then shift {acc,q} right
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc} + ({1'b0, dvs} & {(WIDTH+1){q[0]}});

    // One restoring divide step: shift remainder left, try subtracting divisor
    logic [WIDTH:0] div_sh, div_diff;
    logic           div_ok;
    assign div_sh   = {acc, q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, dvs};
    assign div_ok   = ~div_diff[WIDTH];

    // Sign-corrected results, consumed only when leaving FIX
    logic [2*WIDTH-1:0] prod;
    assign prod = (a_neg ^ b_neg) ? -{acc, q} : {acc, q};

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Control FSM, datapath iteration and HI/LO commit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_r     <= '0;
            a_r      <= '0;
            acc      <= '0;
            q        <= '0;
            dvs      <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            b_zero   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CALC;
                        cnt      <= CW'(WIDTH);
                        op_r     <= op;
                        a_r      <= a;
                        acc      <= '0;
                        q        <= a_mag;
                        dvs      <= b_mag;
                        a_neg    <= a_sgn;
                        b_neg    <= b_sgn;
                        b_zero   <= (b == '0);
                        div_zero <= 1'b0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                    if (op_r[1]) begin
                        acc <= div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], div_ok};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        q   <= {mul_sum[0], q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    state <= S_DONE;
                    if (!op_r[1]) begin
                        {hi, lo} <= prod;
                    end else if (b_zero) begin
                        hi       <= a_r;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        lo <= (a_neg ^ b_neg) ? -q : q;
                        hi <= a_neg ? -acc : acc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): stimulus pushes expected
// HI/LO/div_zero, an independent monitor pops and compares on every done.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           n_vec  = 0;
    int           n_err  = 0;
    int           n_done = 0;
    int           n_push = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("res_hi", hi, e.hi);
                    chk("res_lo", lo, e.lo);
                    chk("res_div_zero", div_zero, e.dz);
                end
            end
        end
    end

    // Issue one op at the current negedge; check latency, busy span, HI/LO retention
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                          input logic wr_too);
        int k, nb;
        start = 1'b1; op = o; a = x; b = y;
        hi_we = wr_too; wdata = 32'hDEAD;
        sb.push_back('{eh, el, ez});
        n_push++;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; a = '0; b = '0;
        k = 0; nb = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy) nb++;
            if (k == 1) begin
                chk("dz_cleared", div_zero, 0);
                chk("hold_hi_calc", hi, m_hi);
                chk("hold_lo_calc", lo, m_lo);
            end
            if (k == W + 1) begin
                chk("hold_hi_fix", hi, m_hi);
                chk("hold_lo_fix", lo, m_lo);
            end
        end while (!done && k < 60);
        chk("latency", k, W + 2);
        chk("busy_cycles", nb, W + 2);
        m_hi = eh; m_lo = el;
        @(negedge clk);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int k;
        rstn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        // first start on the first edge with rstn high
        rstn = 1'b1;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op(2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("dz_holds", div_zero, 1);
        run_op(2'b11, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0);
        // start and hi_we on the same edge: start wins
        run_op(2'b01, 32'd2,        32'd3,        32'h00000000, 32'd6,        1'b0, 1'b1);

        // start and hi_we while busy are ignored
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        sb.push_back('{32'd0, 32'd30, 1'b0});
        n_push++;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1 hi_we = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 60);
        chk("ovl_done_seen", done, 1);
        m_hi = 32'd0; m_lo = 32'd30;
        repeat (40) @(negedge clk);
        chk("ovl_idle", busy, 0);
        chk("ovl_hi", hi, m_hi);

        // reset mid-operation aborts; start during reset ignored
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rstn = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        rstn = 1'b1; start = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (40) @(negedge clk);
        chk("abort_idle", busy, 0);

        // direct writes in IDLE
        lo_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1 lo_we = 1'b0;
        @(negedge clk);
        chk("mtlo_lo", lo, 32'hABCD);
        chk("mtlo_hi", hi, 0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555;
        @(posedge clk); #1 begin hi_we = 1'b0; lo_we = 1'b0; end
        @(negedge clk);
        chk("both_hi", hi, 32'h5555);
        chk("both_lo", lo, 32'h5555);

        repeat (3) @(negedge clk);
        chk("done_count", n_done, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
